banzai_infer_seq: RTL

BANZAI_INFER_SEQ -- requirements
Module: banzai_infer_seq

---
 rtl/banzai_infer_seq.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/banzai_infer_seq.sv
// AXI-Lite sequencer: writes four observations and a mode word, then reads one result.
// Optional watchdog enabled by BANZAI_SEQ_TIMEOUT_EN.
module banzai_infer_seq #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] obs,
  output logic         busy,
  output logic         done,
  output logic [31:0]  result,
  output logic         error,
  output logic [31:0]  m_aw_addr,
  output logic         m_aw_valid,
  input  logic         m_aw_ready,
  output logic [31:0]  m_w_data,
  output logic [3:0]   m_w_strb,
  output logic         m_w_valid,
  input  logic         m_w_ready,
  input  logic [1:0]   m_b_resp,
  input  logic         m_b_valid,
  output logic         m_b_ready,
  output logic [31:0]  m_ar_addr,
  output logic         m_ar_valid,
  input  logic         m_ar_ready,
  input  logic [31:0]  m_r_data,
  input  logic [1:0]   m_r_resp,
  input  logic         m_r_valid,
  output logic         m_r_ready
);

  typedef enum logic [2:0] {
    IDLE, WR_OBS, WR_MODE, RD_RES, FIN
  } state_t;

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic [95:0] obs_q;
  logic        aw_v, w_v, b_r, ar_v, r_r;
  logic [31:0] aw_a, w_d, ar_a, res_q;
  logic        err_q;
  logic        b_hs, r_hs, b_ok, r_ok, tmo;
  logic        issue_wr, issue_rd;
  logic [31:0] wr_addr_n, wr_data_n;

  assign b_hs = b_r & m_b_valid;
  assign r_hs = r_r & m_r_valid;
  assign b_ok = (m_b_resp == 2'b00);
  assign r_ok = (m_r_resp == 2'b00);

`ifdef BANZAI_SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (issue_wr || issue_rd) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TIMEOUT_CYCLES) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  // a handshake landing on the limit cycle still wins over the watchdog
  assign tmo = (state == WR_OBS || state == WR_MODE || state == RD_RES)
             && (tmo_cnt == TIMEOUT_CYCLES) && !b_hs && !r_hs;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo        = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    issue_wr  = 1'b0;
    issue_rd  = 1'b0;
    wr_addr_n = '0;
    wr_data_n = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = WR_OBS;
          idx_n     = 2'd0;
          issue_wr  = 1'b1;
          wr_addr_n = BASE_ADDR + 32'h200C;
          wr_data_n = obs[31:0];
        end
      end
      WR_OBS: begin
        if (tmo) begin
          state_n = FIN;
        end else if (b_hs) begin
          if (!b_ok) begin
            state_n = FIN;
          end else if (idx == 2'd3) begin
            state_n   = WR_MODE;
            issue_wr  = 1'b1;
            wr_addr_n = BASE_ADDR + 32'h201C;
            wr_data_n = 32'h1;
          end else begin
            idx_n     = idx + 2'd1;
            issue_wr  = 1'b1;
            wr_addr_n = BASE_ADDR + 32'h200C + {28'd0, idx_n, 2'b00};
            wr_data_n = obs_q[{idx, 5'd0} +: 32];
          end
        end
      end
      WR_MODE: begin
        if (tmo) begin
          state_n = FIN;
        end else if (b_hs) begin
          if (!b_ok) begin
            state_n = FIN;
          end else begin
            state_n  = RD_RES;
            issue_rd = 1'b1;
          end
        end
      end
      RD_RES: begin
        if (tmo || r_hs) state_n = FIN;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      obs_q <= '0;
      aw_v  <= 1'b0;
      w_v   <= 1'b0;
      b_r   <= 1'b0;
      ar_v  <= 1'b0;
      r_r   <= 1'b0;
      aw_a  <= '0;
      w_d   <= '0;
      ar_a  <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (state == IDLE && start) begin
        obs_q <= obs[127:32];
        err_q <= 1'b0;
      end
      if (issue_wr) begin
        aw_v <= 1'b1;
        w_v  <= 1'b1;
        b_r  <= 1'b1;
        aw_a <= wr_addr_n;
        w_d  <= wr_data_n;
      end else begin
        if (m_aw_ready) aw_v <= 1'b0;
        if (m_w_ready)  w_v  <= 1'b0;
        if (m_b_valid)  b_r  <= 1'b0;
      end
      if (issue_rd) begin
        ar_v <= 1'b1;
        r_r  <= 1'b1;
        ar_a <= BASE_ADDR + 32'h2000;
      end else begin
        if (m_ar_ready) ar_v <= 1'b0;
        if (m_r_valid)  r_r  <= 1'b0;
      end
      if ((state == WR_OBS || state == WR_MODE) && b_hs && !b_ok) err_q <= 1'b1;
      if (state == RD_RES && r_hs) begin
        if (r_ok) res_q <= m_r_data;
        else      err_q <= 1'b1;
      end
      if (tmo) begin
        aw_v  <= 1'b0;
        w_v   <= 1'b0;
        b_r   <= 1'b0;
        ar_v  <= 1'b0;
        r_r   <= 1'b0;
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    busy       = (state != IDLE);
    done       = (state == FIN);
    result     = res_q;
    error      = err_q;
    m_aw_addr  = aw_a;
    m_aw_valid = aw_v;
    m_w_data   = w_d;
    m_w_strb   = 4'hF;
    m_w_valid  = w_v;
    m_b_ready  = b_r;
    m_ar_addr  = ar_a;
    m_ar_valid = ar_v;
    m_r_ready  = r_r;
  end

endmodule
